// File: rtl/verin_avalon2_mem_master_if.sv
// Avalon-MM word-addressed bus between the memory master and the on-chip memory slave.
interface verin_avalon2_mem_master_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/verin_avalon2_mem_master.sv
// Avalon-MM memory master running FILL / COPY / SUM commands, one at a time.
// Optional macro VERIN_MEM_MASTER_PATTERN_INC_EN turns FILL into a ramp (pattern + word index).
module verin_avalon2_mem_master #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WORDS    = 5000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [13:0]         cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    verin_avalon2_mem_master_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                err
);
    localparam int unsigned LEN_W = 14;
    localparam int unsigned CHK_W = 15;
    localparam int unsigned LAT_W = 3;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_SUM  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

`ifdef VERIN_MEM_MASTER_PATTERN_INC_EN
    localparam bit PAT_INC = 1'b1;
`else
    localparam bit PAT_INC = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WR    = 3'd2,
        RD    = 3'd3,
        RWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  pat_q;
    logic [LEN_W-1:0]   i_q;
    logic [DATA_W-1:0]  acc_q;
    logic [LAT_W-1:0]   lat_q;

    logic [LEN_W-1:0]   i_next;
    logic [DATA_W-1:0]  acc_next;
    logic [CHK_W-1:0]   dst_end;
    logic [CHK_W-1:0]   src_end;
    logic               dst_bad;
    logic               src_bad;

    function automatic logic [DATA_W-1:0] fill_word(input logic [DATA_W-1:0] p,
                                                    input logic [LEN_W-1:0]  k);
        return PAT_INC ? p + DATA_W'(k) : p;
    endfunction

    // Region end checks are done one bit wider than the length so dst+len cannot wrap.
    always_comb begin
        i_next   = i_q + LEN_W'(1);
        acc_next = acc_q + bus.avm_readdata;
        dst_end  = CHK_W'(dst_q) + CHK_W'(len_q);
        src_end  = CHK_W'(src_q) + CHK_W'(len_q);
        dst_bad  = (op_q == OP_FILL || op_q == OP_COPY) && (dst_end > CHK_W'(MAX_WORDS));
        src_bad  = (op_q == OP_COPY || op_q == OP_SUM)  && (src_end > CHK_W'(MAX_WORDS));
    end

    assign bus.avm_byteenable = '1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            cmd_ready         <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            result            <= '0;
            bus.avm_read      <= 1'b0;
            bus.avm_write     <= 1'b0;
            bus.avm_address   <= '0;
            bus.avm_writedata <= '0;
            op_q              <= OP_FILL;
            src_q             <= '0;
            dst_q             <= '0;
            len_q             <= '0;
            pat_q             <= '0;
            i_q               <= '0;
            acc_q             <= '0;
            lat_q             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        src_q     <= cmd_src;
                        dst_q     <= cmd_dst;
                        len_q     <= cmd_len;
                        pat_q     <= cmd_pattern;
                        i_q       <= '0;
                        acc_q     <= '0;
                        err       <= 1'b0;
                        result    <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (op_q == OP_RSVD || dst_bad || src_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (len_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (op_q == OP_FILL) begin
                        bus.avm_write     <= 1'b1;
                        bus.avm_address   <= dst_q;
                        bus.avm_writedata <= fill_word(pat_q, '0);
                        state             <= WR;
                    end else begin
                        bus.avm_read    <= 1'b1;
                        bus.avm_address <= src_q;
                        state           <= RD;
                    end
                end
                WR: begin
                    if (!bus.avm_waitrequest) begin
                        i_q <= i_next;
                        if (i_next == len_q) begin
                            bus.avm_write <= 1'b0;
                            result        <= DATA_W'(len_q);
                            done          <= 1'b1;
                            state         <= DONE;
                        end else if (op_q == OP_COPY) begin
                            bus.avm_write   <= 1'b0;
                            bus.avm_read    <= 1'b1;
                            bus.avm_address <= src_q + ADDR_W'(i_next);
                            state           <= RD;
                        end else begin
                            bus.avm_address   <= dst_q + ADDR_W'(i_next);
                            bus.avm_writedata <= fill_word(pat_q, i_next);
                        end
                    end
                end
                RD: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_read <= 1'b0;
                        lat_q        <= '0;
                        state        <= RWAIT;
                    end
                end
                // Readdata is valid READ_LATENCY cycles after the accepting edge.
                RWAIT: begin
                    if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                        if (op_q == OP_COPY) begin
                            bus.avm_write     <= 1'b1;
                            bus.avm_address   <= dst_q + ADDR_W'(i_q);
                            bus.avm_writedata <= bus.avm_readdata;
                            state             <= WR;
                        end else begin
                            acc_q <= acc_next;
                            i_q   <= i_next;
                            if (i_next == len_q) begin
                                result <= acc_next;
                                done   <= 1'b1;
                                state  <= DONE;
                            end else begin
                                bus.avm_read    <= 1'b1;
                                bus.avm_address <= src_q + ADDR_W'(i_next);
                                state           <= RD;
                            end
                        end
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_verin_avalon2_mem_master.sv
// Randomized bench for verin_avalon2_mem_master: memory slave, array reference model, stall checks.
module tb_verin_avalon2_mem_master;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_WORDS = 5000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [13:0]       cmd_len;
    logic [DATA_W-1:0] cmd_pattern;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    bit stall_en = 1'b0;

    verin_avalon2_mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    verin_avalon2_mem_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
        .bus(bus),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory slave: latency-1 reads, writes on accepted cycles.
    logic [31:0] mem [MAX_WORDS] = '{default: 32'h0};
    int unsigned wr_count = 0;

    always @(posedge clk) begin
        if (bus.avm_write && !bus.avm_waitrequest) begin
            if (32'(bus.avm_address) < MAX_WORDS) mem[bus.avm_address] <= bus.avm_writedata;
            wr_count <= wr_count + 1;
        end
        if (bus.avm_read && !bus.avm_waitrequest)
            bus.avm_readdata <= (32'(bus.avm_address) < MAX_WORDS) ? mem[bus.avm_address] : 32'h0;
    end

    // Stall generator plus stability / exclusivity monitor.
    logic [63:0] prev_vec = '0;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [63:0] cur;
        cur = {17'd0, bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        if (reset_n) begin
            if (prev_stall) check("stall_hold", cur, prev_vec);
            check("rd_wr_exclusive", 64'(bus.avm_read & bus.avm_write), 64'd0);
        end
        bus.avm_waitrequest = stall_en && ($urandom_range(0, 2) == 0);
        prev_stall = reset_n && (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
        prev_vec   = cur;
    end

    // Reference model.
    logic [31:0] model_mem [MAX_WORDS];

    function automatic logic [31:0] fill_val(input logic [31:0] pat, input int k);
`ifdef VERIN_MEM_MASTER_PATTERN_INC_EN
        return pat + 32'(k);
`else
        return pat + 32'(k) * 32'd0;
`endif
    endfunction

    task automatic model_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                             input logic [31:0] pat, output logic exp_err,
                             output logic [31:0] exp_res, output int exp_wr);
        exp_err = (op == 2'd3) ||
                  ((op == 2'd0 || op == 2'd1) && (dst + len > int'(MAX_WORDS))) ||
                  ((op == 2'd1 || op == 2'd2) && (src + len > int'(MAX_WORDS)));
        exp_res = 32'h0;
        exp_wr  = 0;
        if (!exp_err && len > 0) begin
            case (op)
                2'd0: begin
                    for (int k = 0; k < len; k++) model_mem[dst + k] = fill_val(pat, k);
                    exp_res = 32'(len);
                    exp_wr  = len;
                end
                2'd1: begin
                    for (int k = 0; k < len; k++) model_mem[dst + k] = model_mem[src + k];
                    exp_res = 32'(len);
                    exp_wr  = len;
                end
                default: begin
                    for (int k = 0; k < len; k++) exp_res = exp_res + model_mem[src + k];
                end
            endcase
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int k = 0; k < int'(MAX_WORDS); k++) if (mem[k] !== model_mem[k]) n++;
        return n;
    endfunction

    task automatic start_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                             input logic [31:0] pat);
        int w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        cmd_op      = op;
        cmd_src     = ADDR_W'(src);
        cmd_dst     = ADDR_W'(dst);
        cmd_len     = 14'(len);
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one command, keep a bogus cmd_valid up while busy, then check completion.
    task automatic run_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                           input logic [31:0] pat, input bit chk_cyc, input int exp_cyc);
        logic        exp_err;
        logic [31:0] exp_res;
        int          exp_wr;
        int unsigned w0;
        int          cyc;
        bit          seen;
        string       t;
        t = $sformatf("op%0d_s%0d_d%0d_l%0d", op, src, dst, len);
        model_cmd(op, src, dst, len, pat, exp_err, exp_res, exp_wr);
        @(negedge clk);
        w0 = wr_count;
        start_cmd(op, src, dst, len, pat);
        cmd_op      = 2'd0;
        cmd_dst     = ADDR_W'(0);
        cmd_len     = 14'd7;
        cmd_pattern = $urandom;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        check({t, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({t, "_err"}, 64'(err), 64'(exp_err));
            check({t, "_result"}, 64'(result), 64'(exp_res));
            check({t, "_writes"}, 64'(wr_count - w0), 64'(exp_wr));
            check({t, "_mem"}, 64'(mem_diff()), 64'd0);
            if (chk_cyc) check({t, "_cycles"}, 64'(cyc), 64'(exp_cyc));
            @(negedge clk);
            check({t, "_busy_after"}, 64'(busy), 64'd0);
            check({t, "_ready_after"}, 64'(cmd_ready), 64'd1);
            check({t, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int unsigned w0;
        int          w;
        for (int k = 0; k < int'(MAX_WORDS); k++) model_mem[k] = 32'h0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        cmd_pattern = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_strobes", 64'({bus.avm_read, bus.avm_write}), 64'd0);
        check("rst_address", 64'(bus.avm_address), 64'd0);
        check("rst_writedata", 64'(bus.avm_writedata), 64'd0);
        check("byteenable", 64'(bus.avm_byteenable), 64'hF);

        // Directed: FILL back-to-back, COPY alternating, SUM with wrap.
        run_cmd(2'd0, 0, 'h100, 4, 32'hA5A5_0001, 1'b1, 6);
        run_cmd(2'd1, 'h100, 'h200, 4, 32'h0, 1'b1, 14);
        run_cmd(2'd0, 0, 0, 1, 32'hFFFF_FFFF, 1'b1, 3);
        run_cmd(2'd0, 0, 1, 1, 32'h2, 1'b0, 0);
        run_cmd(2'd0, 0, 2, 1, 32'h5, 1'b0, 0);
        run_cmd(2'd2, 0, 0, 3, 32'h0, 1'b1, 8);
        check("sum_wrap_value", 64'(result), 64'h6);

        // COPY under random waitrequest.
        run_cmd(2'd0, 0, 'h500, 8, 32'h1234_0000, 1'b0, 0);
        stall_en = 1'b1;
        run_cmd(2'd1, 'h500, 'h600, 8, 32'h0, 1'b0, 0);
        stall_en = 1'b0;

        // Range, reserved-op and zero-length cases; boundary exactly at MAX_WORDS succeeds.
        run_cmd(2'd0, 0, 4998, 3, 32'hDEAD_BEEF, 1'b1, 2);
        run_cmd(2'd3, 0, 0, 4, 32'h0, 1'b1, 2);
        run_cmd(2'd0, 0, 'h700, 0, 32'h1, 1'b1, 2);
        run_cmd(2'd1, 4995, 0, 10, 32'h0, 1'b1, 2);
        run_cmd(2'd2, 4991, 0, 10, 32'h0, 1'b1, 2);
        run_cmd(2'd0, 0, 4997, 3, 32'hCAFE_0000, 1'b1, 5);
        run_cmd(2'd2, 4997, 0, 3, 32'h0, 1'b1, 8);
        run_cmd(2'd1, 'h200, 'h202, 6, 32'h0, 1'b0, 0);

        // Randomized mix with stalls.
        stall_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_cmd(op, int'($urandom_range(0, 5010)), int'($urandom_range(0, 5010)),
                    int'($urandom_range(0, 24)), $urandom, 1'b0, 0);
        end
        stall_en = 1'b0;

        // Reset in the middle of a COPY, then a SUM over the partially copied region.
        run_cmd(2'd0, 0, 'h300, 16, 32'h7700_0000, 1'b0, 0);
        @(negedge clk);
        w0 = wr_count;
        start_cmd(2'd1, 'h300, 'h400, 16, 32'h0);
        cmd_valid = 1'b0;
        w = 0;
        while ((wr_count - w0) < 5 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_word5", 64'(wr_count - w0), 64'd5);
        for (int k = 0; k < 5; k++) model_mem['h400 + k] = model_mem['h300 + k];
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_strobes", 64'({bus.avm_read, bus.avm_write}), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(cmd_ready), 64'd1);
        check("abort_mem", 64'(mem_diff()), 64'd0);
        run_cmd(2'd2, 'h400, 0, 16, 32'h0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
